// File: rtl/digit_counter_3bits_pkg.sv
// digit_counter_3bits_pkg
// Shared constants and types for the 3-bit digit counter:
//   DIGIT_W / DIGIT_MAX   - width and top value of the displayed digit
//   DEBOUNCE_CYCLES_DEF   - default number of stable cycles before a button level is accepted
//   wrap_e                - overflow behaviour at the 0/7 boundaries
package digit_counter_3bits_pkg;
   localparam int                 DIGIT_W             = 3;
   localparam logic [DIGIT_W-1:0] DIGIT_MAX           = 3'd7;
   localparam int                 DEBOUNCE_CYCLES_DEF = 4;

   typedef enum logic {
      WRAP_SATURATE = 1'b0,
      WRAP_MODULO   = 1'b1
   } wrap_e;
endpackage

// File: rtl/digit_counter_3bits_if.sv
// digit_counter_3bits_if
// Button inputs and digit outputs of the counter.
//   btn_up/btn_down/btn_clear - raw asynchronous buttons, active-high
//   count_out                 - current digit 0..7
//   carry / borrow            - one-cycle pulses on 7->0 / 0->7 wrap
// master: the side pressing buttons; slave: the counter.
interface digit_counter_3bits_if;
   import digit_counter_3bits_pkg::*;

   logic               btn_up;
   logic               btn_down;
   logic               btn_clear;
   logic [DIGIT_W-1:0] count_out;
   logic               carry;
   logic               borrow;

   modport master (
      output btn_up, btn_down, btn_clear,
      input  count_out, carry, borrow
   );

   modport slave (
      input  btn_up, btn_down, btn_clear,
      output count_out, carry, borrow
   );
endinterface

// File: rtl/digit_counter_3bits_button_debouncer.sv
// button_debouncer
// Two-flop synchronizer, level debouncer and rising-edge press detector
// for one raw button.
//   clk, rst - clock, asynchronous active-high reset
//   raw      - raw asynchronous button level
//   level    - accepted (debounced) level
//   press    - one-cycle pulse when the accepted level goes 0->1
module button_debouncer
   import digit_counter_3bits_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic press
);
   // The counter flips the level on the cycle it would reach DEBOUNCE_CYCLES,
   // so compare against one less and never actually store the final value.
   localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

   logic [1:0] sync_q, sync_d;
   logic [7:0] cnt_q, cnt_d;
   logic       level_q, level_d;
   logic       press_q, press_d;

   always_comb begin
      sync_d  = {sync_q[0], raw};
      cnt_d   = '0;
      level_d = level_q;
      press_d = 1'b0;
      if (sync_q[1] != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync_q[1];
            // Only the release->press direction generates a pulse.
            press_d = sync_q[1];
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         press_q <= press_d;
      end
   end

   assign level = level_q;
   assign press = press_q;
endmodule

// File: rtl/digit_counter_3bits.sv
// digit_counter_3bits
// Up/down/clear digit counter 0..7 driven by three debounced buttons.
//   clk, rst - clock, asynchronous active-high reset
//   bus      - slave side of digit_counter_3bits_if (buttons in, digit/carry/borrow out)
// Parameters: DEBOUNCE_CYCLES (1..255), WRAP (1 = modulo-8, 0 = saturate).
module digit_counter_3bits
   import digit_counter_3bits_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter bit WRAP            = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst,
   digit_counter_3bits_if.slave   bus
);
   localparam bit WRAP_MOD = (wrap_e'(WRAP) == WRAP_MODULO);

   logic up_p, down_p, clear_p;

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
      .clk(clk), .rst(rst), .raw(bus.btn_up), .level(), .press(up_p)
   );
   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
      .clk(clk), .rst(rst), .raw(bus.btn_down), .level(), .press(down_p)
   );
   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
      .clk(clk), .rst(rst), .raw(bus.btn_clear), .level(), .press(clear_p)
   );

   logic [DIGIT_W-1:0] count_q, count_d;
   logic               carry_q, carry_d;
   logic               borrow_q, borrow_d;

   always_comb begin
      count_d  = count_q;
      carry_d  = 1'b0;
      borrow_d = 1'b0;
      if (clear_p) begin
         count_d = '0;
      end else if (up_p && down_p) begin
         // Simultaneous up and down cancel out.
      end else if (up_p) begin
         if (count_q == DIGIT_MAX) begin
            if (WRAP_MOD) begin
               count_d = '0;
               carry_d = 1'b1;
            end
         end else begin
            count_d = count_q + DIGIT_W'(1);
         end
      end else if (down_p) begin
         if (count_q == '0) begin
            if (WRAP_MOD) begin
               count_d  = DIGIT_MAX;
               borrow_d = 1'b1;
            end
         end else begin
            count_d = count_q - DIGIT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q  <= '0;
         carry_q  <= 1'b0;
         borrow_q <= 1'b0;
      end else begin
         count_q  <= count_d;
         carry_q  <= carry_d;
         borrow_q <= borrow_d;
      end
   end

   assign bus.count_out = count_q;
   assign bus.carry     = carry_q;
   assign bus.borrow    = borrow_q;
endmodule
